// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Two-port arbiter in front of a single-port synchronous memory. The loader
// port wins by default; after MAX_BURST consecutive loader grants taken while
// the core is waiting, the core is given exactly one forced turn. Grants are
// combinational, so every granted access completes in the cycle it is
// granted. Read data comes back one cycle later, and the valid flag goes to
// whichever port issued the read.
//
// Ports
//   clk, nrst                    clock, synchronous active-low reset
//   core_req/wre/ad/din          core access request (write when wre=1)
//   core_gnt, core_stall         core access issued / core waiting this cycle
//   core_rvalid, core_rdata      core read data, one cycle after a read grant
//   ld_req/wre/ad/din            loader access request
//   ld_gnt, ld_rvalid, ld_rdata  loader grant and read return
//   mem_ce/wre/ad/din            single-port memory drive
//   mem_dout                     memory read data (registered inside memory)
// -----------------------------------------------------------------------------
module mem_arbiter #(
   parameter int MAX_BURST = 4
) (
   input  logic        clk,
   input  logic        nrst,
   input  logic        core_req,
   input  logic        core_wre,
   input  logic [7:0]  core_ad,
   input  logic [31:0] core_din,
   output logic        core_gnt,
   output logic        core_stall,
   output logic        core_rvalid,
   output logic [31:0] core_rdata,
   input  logic        ld_req,
   input  logic        ld_wre,
   input  logic [7:0]  ld_ad,
   input  logic [31:0] ld_din,
   output logic        ld_gnt,
   output logic        ld_rvalid,
   output logic [31:0] ld_rdata,
   output logic        mem_ce,
   output logic        mem_wre,
   output logic [7:0]  mem_ad,
   output logic [31:0] mem_din,
   input  logic [31:0] mem_dout
);

   localparam logic [3:0] MaxBurst = 4'(MAX_BURST);

   typedef enum logic [1:0] {
      IDLE,   // no grant last cycle
      LOAD,   // loader granted last cycle
      CORE,   // core granted last cycle
      FORCE   // core owed a turn after a full loader burst
   } arbState;

   arbState    state;
   arbState    nextState;
   logic [3:0] burstCnt;
   logic [3:0] burstNext;
   logic [1:0] rdOwner;   // {core read, loader read} issued last cycle
   logic       coreGnt;
   logic       ldGnt;

   // ---------------------------------------------------------------------------
   // Grant decision. Reset masks every grant so nothing reaches the memory.
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal assigned in a combinational block gets a default
      // first, so no path through the if/else leaves it unassigned (a latch).
      coreGnt = 1'b0;
      ldGnt   = 1'b0;
      if (nrst) begin
         if (state == FORCE && core_req) begin
            coreGnt = 1'b1;
         end else if (ld_req) begin
            ldGnt = 1'b1;
         end else if (core_req) begin
            coreGnt = 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Burst counter and next state. FORCE is entered on the edge where the
   // counter reaches MAX_BURST, so the core gets its grant in the very next
   // cycle (L x MAX_BURST, then C).
   // ---------------------------------------------------------------------------
   always_comb begin
      burstNext = burstCnt;
      if (!core_req || coreGnt) begin
         burstNext = 4'd0;
      end else if (ldGnt && burstCnt != MaxBurst) begin
         burstNext = burstCnt + 4'd1;
      end

      nextState = IDLE;
      if (state == FORCE) begin
         nextState = coreGnt ? CORE : IDLE;
      end else if (core_req && burstNext == MaxBurst) begin
         nextState = FORCE;
      end else if (ldGnt) begin
         nextState = LOAD;
      end else if (coreGnt) begin
         nextState = CORE;
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: registers take non-blocking assignments so every flop samples
      // values from before the edge, regardless of statement order.
      if (!nrst) begin
         state    <= IDLE;
         burstCnt <= 4'd0;
         rdOwner  <= 2'b00;
      end else begin
         state    <= nextState;
         burstCnt <= burstNext;
         rdOwner  <= {coreGnt & ~core_wre, ldGnt & ~ld_wre};
      end
   end

   // ---------------------------------------------------------------------------
   // Memory drive: taken from the granted port, all zero when idle.
   // ---------------------------------------------------------------------------
   always_comb begin
      mem_wre = 1'b0;
      mem_ad  = 8'd0;
      mem_din = 32'd0;
      if (coreGnt) begin
         mem_wre = core_wre;
         mem_ad  = core_ad;
         mem_din = core_din;
      end else if (ldGnt) begin
         mem_wre = ld_wre;
         mem_ad  = ld_ad;
         mem_din = ld_din;
      end
   end

   assign mem_ce     = coreGnt | ldGnt;
   assign core_gnt   = coreGnt;
   assign ld_gnt     = ldGnt;
   assign core_stall = nrst & core_req & ~coreGnt;

   // rdOwner still holds last cycle's read during the first reset cycle;
   // gating with nrst drops that pending return immediately.
   assign core_rvalid = nrst & rdOwner[1];
   assign ld_rvalid   = nrst & rdOwner[0];
   assign core_rdata  = mem_dout;
   assign ld_rdata    = mem_dout;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Directed scenarios followed by randomized traffic. A small reference model
// (loader run length, pending-read bookkeeping, shadow memory array) predicts
// every output each cycle; a behavioural RAM drives mem_dout.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

   localparam int MaxBurst = 4;

   logic        clk = 1'b0;
   logic        nrst;
   logic        core_req, core_wre;
   logic [7:0]  core_ad;
   logic [31:0] core_din;
   logic        core_gnt, core_stall, core_rvalid;
   logic [31:0] core_rdata;
   logic        ld_req, ld_wre;
   logic [7:0]  ld_ad;
   logic [31:0] ld_din;
   logic        ld_gnt, ld_rvalid;
   logic [31:0] ld_rdata;
   logic        mem_ce, mem_wre;
   logic [7:0]  mem_ad;
   logic [31:0] mem_din;
   logic [31:0] mem_dout = 32'd0;

   int checkCnt = 0;
   int errCnt   = 0;

   mem_arbiter #(.MAX_BURST(MaxBurst)) dut (
      .clk(clk), .nrst(nrst),
      .core_req(core_req), .core_wre(core_wre), .core_ad(core_ad), .core_din(core_din),
      .core_gnt(core_gnt), .core_stall(core_stall), .core_rvalid(core_rvalid),
      .core_rdata(core_rdata),
      .ld_req(ld_req), .ld_wre(ld_wre), .ld_ad(ld_ad), .ld_din(ld_din),
      .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
      .mem_ce(mem_ce), .mem_wre(mem_wre), .mem_ad(mem_ad), .mem_din(mem_din),
      .mem_dout(mem_dout)
   );

   always #5 clk = ~clk;

   // Behavioural single-port RAM with one-cycle read latency.
   logic [31:0] ram [256];
   always @(posedge clk) begin
      if (mem_ce) begin
         if (mem_wre) ram[mem_ad] <= mem_din;
         else         mem_dout    <= ram[mem_ad];
      end
   end

   // Reference model state.
   logic [31:0] modelMem [256];
   int          ldRun;        // loader grants taken while the core waited
   logic        corePend;     // core read issued last cycle
   logic        ldPend;       // loader read issued last cycle
   logic [31:0] pendData;     // data that read will return

   // Last sampled values, for scenario-level pattern checks.
   logic        lastCoreGnt, lastLdGnt, lastCoreRvalid;
   logic [31:0] lastCoreRdata;

   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checkCnt++;
      if (got !== exp) begin
         errCnt++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   // Apply one cycle of stimulus, check outputs mid-cycle, advance the model.
   task automatic doCycle(input logic rstV,
                          input logic cReq, input logic cWre, input logic [7:0] cAd,
                          input logic [31:0] cDin,
                          input logic lReq, input logic lWre, input logic [7:0] lAd,
                          input logic [31:0] lDin);
      logic        expCg, expLg, expWre;
      logic [7:0]  expAd;
      logic [31:0] expDin;
      nrst = rstV;
      core_req = cReq; core_wre = cWre; core_ad = cAd; core_din = cDin;
      ld_req = lReq;   ld_wre = lWre;   ld_ad = lAd;   ld_din = lDin;
      @(negedge clk);

      // The core is owed a turn once MaxBurst loader grants went by while it waited.
      expCg = 1'b0;
      expLg = 1'b0;
      if (rstV) begin
         if (ldRun >= MaxBurst && cReq) expCg = 1'b1;
         else if (lReq)                 expLg = 1'b1;
         else if (cReq)                 expCg = 1'b1;
      end
      expWre = expCg ? cWre : (expLg ? lWre : 1'b0);
      expAd  = expCg ? cAd  : (expLg ? lAd  : 8'd0);
      expDin = expCg ? cDin : (expLg ? lDin : 32'd0);

      checkVal("core_gnt",    32'(core_gnt),    32'(expCg));
      checkVal("ld_gnt",      32'(ld_gnt),      32'(expLg));
      checkVal("core_stall",  32'(core_stall),  32'(rstV & cReq & ~expCg));
      checkVal("mem_ce",      32'(mem_ce),      32'(expCg | expLg));
      checkVal("mem_wre",     32'(mem_wre),     32'(expWre));
      checkVal("mem_ad",      32'(mem_ad),      32'(expAd));
      checkVal("mem_din",     mem_din,          expDin);
      checkVal("core_rvalid", 32'(core_rvalid), 32'(rstV & corePend));
      checkVal("ld_rvalid",   32'(ld_rvalid),   32'(rstV & ldPend));
      if (rstV && corePend) checkVal("core_rdata", core_rdata, pendData);
      if (rstV && ldPend)   checkVal("ld_rdata",   ld_rdata,   pendData);

      lastCoreGnt    = core_gnt;
      lastLdGnt      = ld_gnt;
      lastCoreRvalid = core_rvalid;
      lastCoreRdata  = core_rdata;

      if (!rstV) begin
         ldRun    = 0;
         corePend = 1'b0;
         ldPend   = 1'b0;
      end else begin
         if (!cReq || expCg) ldRun = 0;
         else if (expLg)     ldRun = ldRun + 1;
         corePend = expCg & ~cWre;
         ldPend   = expLg & ~lWre;
         if (expCg || expLg) begin
            if (expWre) modelMem[expAd] = expDin;
            else        pendData = modelMem[expAd];
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idleCycle();
      doCycle(1'b1, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 8'h00, 32'h0);
   endtask

   task automatic bothCycle();
      doCycle(1'b1, 1'b1, 1'b0, 8'h40, 32'h0, 1'b1, 1'b1, 8'h41, 32'h5555_0000);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [9:0] ldPattern;
      logic [4:0] ldPattern5;
      for (int i = 0; i < 256; i++) begin
         ram[i]      = 32'hA5A5_0000 ^ 32'(i * 7);
         modelMem[i] = 32'hA5A5_0000 ^ 32'(i * 7);
      end
      ldRun = 0; corePend = 1'b0; ldPend = 1'b0; pendData = 32'd0;
      nrst = 1'b0;
      core_req = 1'b0; core_wre = 1'b0; core_ad = 8'd0; core_din = 32'd0;
      ld_req = 1'b0;   ld_wre = 1'b0;   ld_ad = 8'd0;   ld_din = 32'd0;
      @(posedge clk);
      #1;

      // Reset held with both ports requesting: nothing granted, no stall.
      doCycle(1'b0, 1'b1, 1'b1, 8'h10, 32'h1, 1'b1, 1'b0, 8'h11, 32'h2);
      doCycle(1'b0, 1'b1, 1'b0, 8'h10, 32'h1, 1'b1, 1'b1, 8'h11, 32'h2);

      // No requests: memory idle, no read returns.
      repeat (3) idleCycle();

      // Core write then read of 0x10, returned one cycle later.
      doCycle(1'b1, 1'b1, 1'b1, 8'h10, 32'hDEAD_BEEF, 1'b0, 1'b0, 8'h00, 32'h0);
      doCycle(1'b1, 1'b1, 1'b0, 8'h10, 32'h0, 1'b0, 1'b0, 8'h00, 32'h0);
      idleCycle();
      checkVal("req038_rvalid", 32'(lastCoreRvalid), 32'd1);
      checkVal("req038_rdata",  lastCoreRdata,       32'hDEAD_BEEF);

      // Contention for 10 cycles: L,L,L,L,C,L,L,L,L,C.
      ldPattern = '0;
      for (int i = 0; i < 10; i++) begin
         bothCycle();
         ldPattern = {ldPattern[8:0], lastLdGnt};
         if (lastLdGnt && lastCoreGnt) checkVal("both_granted", 32'd1, 32'd0);
      end
      checkVal("burst_pattern", 32'(ldPattern), 32'b11_1101_1110);

      // Loader read at 0x20, then core write: loader read data lands in the
      // core-write cycle.
      doCycle(1'b1, 1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 8'h20, 32'h0);
      doCycle(1'b1, 1'b1, 1'b1, 8'h33, 32'h1234_5678, 1'b0, 1'b0, 8'h00, 32'h0);

      // core_req dropped after two loader grants restarts the burst count.
      bothCycle();
      bothCycle();
      doCycle(1'b1, 1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b1, 8'h42, 32'h6666_0000);
      ldPattern5 = '0;
      for (int i = 0; i < 5; i++) begin
         bothCycle();
         ldPattern5 = {ldPattern5[3:0], lastLdGnt};
      end
      checkVal("restart_pattern", 32'(ldPattern5), 32'b1_1110);

      // Reset right after a core read grant suppresses its return.
      doCycle(1'b1, 1'b1, 1'b0, 8'h10, 32'h0, 1'b0, 1'b0, 8'h00, 32'h0);
      doCycle(1'b0, 1'b1, 1'b0, 8'h10, 32'h0, 1'b1, 1'b0, 8'h20, 32'h0);
      checkVal("rst_rvalid", 32'(lastCoreRvalid), 32'd0);
      bothCycle();
      checkVal("post_rst_ld", 32'(lastLdGnt), 32'd1);
      // Reach FORCE, then reset: FORCE must be cleared.
      repeat (3) bothCycle();
      doCycle(1'b0, 1'b1, 1'b0, 8'h40, 32'h0, 1'b1, 1'b1, 8'h41, 32'h0);
      bothCycle();
      checkVal("force_cleared", 32'(lastLdGnt), 32'd1);

      // Randomized traffic with occasional reset.
      for (int i = 0; i < 2000; i++) begin
         doCycle(($urandom_range(39) != 0),
                 ($urandom_range(9) < 7), 1'($urandom), 8'($urandom), $urandom,
                 ($urandom_range(9) < 7), 1'($urandom), 8'($urandom), $urandom);
      end

      $display("Simulation finished: %0d checks, %0d errors", checkCnt, errCnt);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: MAX_BURST, default 4, maximum consecutive loader grants while core_req is pending; legal range 1..15.
REQ-002 clk  in  1  system clock; all state updates on rising edge.
REQ-003 nrst  in  1  reset, synchronous, active-low.
REQ-004 core_req  in  1  core requests one memory access this cycle.
REQ-005 core_wre  in  1  core access is a write (1) or read (0).
REQ-006 core_ad  in  8  core word address.
REQ-007 core_din  in  32  core write data.
REQ-008 core_gnt  out  1  core access is issued to memory this cycle.
REQ-009 core_stall  out  1  core_req high and core_gnt low; the control FSM holds its state.
REQ-010 core_rvalid  out  1  core read data valid on core_rdata.
REQ-011 core_rdata  out  32  equals mem_dout.
REQ-012 ld_req, ld_wre, ld_ad[7:0], ld_din[31:0]  in  loader port; same meaning as the core port.
REQ-013 ld_gnt  out  1; ld_rvalid  out  1; ld_rdata  out  32 (equals mem_dout).
REQ-014 mem_ce  out  1; mem_wre  out  1; mem_ad  out  8; mem_din  out  32  single-port memory drive.
REQ-015 mem_dout  in  32  memory read data, valid one cycle after the read is issued.

Function
REQ-016 The block is a single-port memory arbiter: at most one of core_gnt and ld_gnt SHALL be high in any cycle.
REQ-017 Grants SHALL be combinational from the requests, state and nrst; a granted access SHALL complete in the same cycle. No request queuing.
REQ-018 Priority: the loader wins by default. The core wins only in FORCE state or when ld_req is low.
REQ-019 burst_cnt (4 bits) SHALL increment on each ld_gnt cycle while core_req is high, saturating at MAX_BURST.
REQ-020 burst_cnt SHALL clear on any core_gnt cycle, and on any cycle where core_req is low.
REQ-021 FSM states: IDLE (no grant last cycle), LOAD (loader granted last cycle), CORE (core granted last cycle), FORCE.
REQ-022 Transition to FORCE SHALL occur when burst_cnt reaches MAX_BURST with core_req high.
REQ-023 In FORCE the core SHALL be granted if core_req is high.
REQ-024 FORCE SHALL exit to CORE on core_gnt, or to IDLE if core_req has dropped.
REQ-025 Outside FORCE, the next state SHALL be LOAD on ld_gnt, CORE on core_gnt, and IDLE otherwise.
REQ-026 mem_ce = core_gnt | ld_gnt.
REQ-027 mem_wre, mem_ad and mem_din SHALL be taken from the granted port; all are 0 when there is no grant.
REQ-028 rd_owner register SHALL capture {core_gnt & ~core_wre, ld_gnt & ~ld_wre} each cycle.
REQ-029 core_rvalid and ld_rvalid SHALL equal the corresponding rd_owner bit, giving read latency of exactly 1 cycle after the grant.
REQ-030 Writes SHALL produce no rvalid.
REQ-031 Back-to-back grants SHALL be allowed every cycle. A read grant followed by any grant the next cycle SHALL still deliver rvalid for the earlier read.
REQ-032 A simultaneous core_req and ld_req outside FORCE SHALL grant the loader and stall the core.
REQ-033 A request dropped while stalled SHALL leave no residual state except the burst_cnt clear per REQ-020.

Reset
REQ-034 While nrst is low at a rising edge, state SHALL go to IDLE, and burst_cnt and rd_owner SHALL clear to 0.
REQ-035 While nrst is low, core_gnt, ld_gnt, mem_ce and mem_wre SHALL be forced to 0, and core_stall SHALL be 0.
REQ-036 Reset asserted mid-burst or one cycle after a read grant SHALL suppress the pending rvalid and clear FORCE.
REQ-037 The first grant SHALL be possible in the first cycle with nrst high.

Verification
REQ-038 Core only: core_req=1, core_wre=1, ad=0x10, din=0xDEADBEEF, then a read of 0x10 -> core_gnt the same cycle, no stall, core_rvalid one cycle later with core_rdata=0xDEADBEEF.
REQ-039 Contention with MAX_BURST=4: both requests held high for 10 cycles -> grant pattern L,L,L,L,C,L,L,L,L,C; core_stall high on every L cycle; never both grants high.
REQ-040 Loader read at 0x20 followed by a core write the next cycle -> ld_rvalid=1 and core_rvalid=0 in the core-write cycle; mem_wre=1, mem_ad=core_ad.
REQ-041 core_req drops after 2 loader grants, then rises again -> burst_cnt restarts from 0; 4 more loader grants precede the forced core grant.
REQ-042 nrst low in the cycle after a core read grant, and while in FORCE -> core_rvalid stays 0, all grants 0, FSM in IDLE; the first cycle after release with ld_req=core_req=1 grants the loader.
REQ-043 No requests -> mem_ce=0, mem_ad=0, both rvalid 0, FSM stays in IDLE.
